// File: rtl/hdc_fp16_pkg.sv
// FP16 type, constants and helpers shared by the HDC scoring datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hdc_fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    localparam logic [4:0]  FP16_EXP_MAX  = 5'd31;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

    // NaN: all-ones exponent with a non-zero fraction (Inf has frac == 0).
    function automatic logic fp16_is_nan(input fp16_t v);
        return (v.exp == FP16_EXP_MAX) && (v.frac != 10'd0);
    endfunction

endpackage

// File: rtl/fp16_class_argmax_if.sv
// Score stream in / argmax result out bundle for the class argmax stage.
// Latency: n/a (wires only).
// Backpressure: score_ready throttles the score sender, result_ready holds the result.
interface fp16_class_argmax_if #(
    parameter int NUM_CLASSES = 10
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic             score_valid;
    logic             score_ready;
    logic [15:0]      score_data;
    logic             score_last;
    logic             result_valid;
    logic             result_ready;
    logic [IDX_W-1:0] result_class;
    logic [15:0]      result_score;
    logic             result_err;

    // Upstream accumulator / downstream consumer side.
    modport master (
        output score_valid, score_data, score_last, result_ready,
        input  score_ready, result_valid, result_class, result_score, result_err
    );

    // Argmax block side.
    modport slave (
        input  score_valid, score_data, score_last, result_ready,
        output score_ready, result_valid, result_class, result_score, result_err
    );

endinterface

// File: rtl/fp16_gt.sv
// Strict greater-than on FP16 values: sign-magnitude order, +0 == -0, NaN never wins.
// Latency: combinational.
// Backpressure: n/a.
module fp16_gt
    import hdc_fp16_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output logic  a_gt_b
);

    logic [14:0] mag_a;
    logic [14:0] mag_b;
    logic        a_nan;
    logic        b_nan;
    logic        both_zero;

    assign mag_a = {a.exp, a.frac};
    assign mag_b = {b.exp, b.frac};
    assign a_nan = fp16_is_nan(a);
    assign b_nan = fp16_is_nan(b);
    // OR-ing in the sign bit maps both zero encodings onto -0.
    assign both_zero = ((a | FP16_NEG_ZERO) == FP16_NEG_ZERO) &&
                       ((b | FP16_NEG_ZERO) == FP16_NEG_ZERO);

    // NaN a never wins; any number beats a NaN b so a NaN seed is displaced.
    // Inf needs no special case: it already has the largest magnitude.
    always_comb begin
        a_gt_b = 1'b0;
        if (a_nan) begin
            a_gt_b = 1'b0;
        end else if (b_nan) begin
            a_gt_b = 1'b1;
        end else if (both_zero) begin
            a_gt_b = 1'b0;
        end else if (a.sign != b.sign) begin
            a_gt_b = b.sign;
        end else if (!a.sign) begin
            a_gt_b = (mag_a > mag_b);
        end else begin
            a_gt_b = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fp16_class_argmax.sv
// Running argmax over NUM_CLASSES FP16 scores per query; reports winning class and score.
// Latency: result_valid rises the cycle after the final score transfer.
// Backpressure: score_ready drops while a result waits; the result holds until result_ready.
module fp16_class_argmax #(
    parameter int NUM_CLASSES = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    fp16_class_argmax_if.slave   bus
);
    import hdc_fp16_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    fp16_t            best;
    fp16_t            score;
    logic             err;
    logic             rdy_en;
    logic             score_xfer;
    logic             result_xfer;
    logic             final_xfer;
    logic             score_gt;
    logic             take;

    assign score       = fp16_t'(bus.score_data);
    assign score_xfer  = bus.score_valid && bus.score_ready;
    assign result_xfer = bus.result_valid && bus.result_ready;
    // A query ends on score_last or when the class count is exhausted, whichever first.
    assign final_xfer  = score_xfer && (bus.score_last || (cnt == LAST_IDX));

    fp16_gt u_gt (
        .a      (score),
        .b      (best),
        .a_gt_b (score_gt)
    );

    // First score seeds the best value unconditionally; later ones must be strictly greater.
    assign take = (cnt == '0) || score_gt;

    // State register; rdy_en keeps score_ready low until the cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    // Next-state: close the query on its final score, reopen once the result is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (final_xfer)  state_nxt = DONE;
            DONE:    if (result_xfer) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.score_ready  = (state == COLLECT) && rdy_en;
        bus.result_valid = (state == DONE);
    end

    // Running maximum, element counter and length-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            best     <= fp16_t'(FP16_POS_ZERO);
            best_idx <= '0;
            err      <= 1'b0;
        end else begin
            if (score_xfer) begin
                cnt <= cnt + IDX_W'(1);
                if (take) begin
                    best     <= score;
                    best_idx <= cnt;
                end
            end
            if (final_xfer) begin
                // Ending on the count without score_last means the query overran.
                err <= bus.score_last ? (cnt != LAST_IDX) : 1'b1;
            end
            if (result_xfer) begin
                cnt <= '0;
                err <= 1'b0;
            end
        end
    end

    assign bus.result_class = best_idx;
    assign bus.result_score = best;
    assign bus.result_err   = err;

endmodule

// File: tb/tb_fp16_class_argmax.sv
module tb_fp16_class_argmax;

    localparam int N = 10;

    typedef struct {
        int          cls;
        logic [15:0] sc;
        logic        er;
    } exp_t;

    logic clk;
    logic rst;
    logic rr_hold;
    logic rr_rand;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [15:0] vec [16];

    fp16_class_argmax_if #(.NUM_CLASSES(N)) bus ();

    fp16_class_argmax #(.NUM_CLASSES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
    endtask

    // result_ready driver: always high, held low, or random.
    initial begin
        bus.result_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_hold)      bus.result_ready = 1'b0;
            else if (rr_rand) bus.result_ready = 1'($urandom_range(0, 1));
            else              bus.result_ready = 1'b1;
        end
    end

    // Scoreboard monitor: compare every accepted result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.result_valid && bus.result_ready) begin
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    check("result_class", 32'(bus.result_class), 32'(e.cls));
                    check("result_score", 32'(bus.result_score), 32'(e.sc));
                    check("result_err",   32'(bus.result_err),   32'(e.er));
                end
            end
        end
    end

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 16; i++) vec[i] = v;
    endtask

    task automatic drive_score(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        bus.score_valid = 1'b1;
        bus.score_data  = d;
        bus.score_last  = l;
        @(negedge clk);
        while (!bus.score_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.score_ready) timeout_fail("score_accept");
        @(posedge clk);
        #1;
        bus.score_valid = 1'b0;
        bus.score_data  = 16'hDEAD;
        bus.score_last  = 1'b0;
    endtask

    task automatic run_query(input int n, input bit use_last, input int cls,
                             input logic [15:0] sc, input logic er, input bit gaps);
        exp_t e;
        e.cls = cls;
        e.sc  = sc;
        e.er  = er;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            drive_score(vec[i], use_last && (i == n - 1));
            if (i == n - 1) begin
                @(negedge clk);
                check("result_latency", 32'(bus.result_valid), 32'd1);
                @(posedge clk);
                #1;
            end else if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_score_ready"},  32'(bus.score_ready),  32'd0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_result_class"}, 32'(bus.result_class), 32'd0);
        check({tag, "_result_score"}, 32'(bus.result_score), 32'd0);
        check({tag, "_result_err"},   32'(bus.result_err),   32'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        checks = 0;
        errors = 0;
        rr_hold = 1'b0;
        rr_rand = 1'b0;
        rst = 1'b1;
        bus.score_valid = 1'b0;
        bus.score_data  = 16'hDEAD;
        bus.score_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(bus.score_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic maximum.
        fill(16'hC000);
        vec[0] = 16'h3C00; vec[1] = 16'h4000; vec[2] = 16'hBC00; vec[3] = 16'h3800;
        run_query(N, 1, 1, 16'h4000, 1'b0, 0);

        // All equal: lowest index wins.
        fill(16'h3C00);
        run_query(N, 1, 0, 16'h3C00, 1'b0, 0);

        // -0 then +0 compare equal, winner keeps its own encoding.
        fill(16'hC000);
        vec[0] = 16'h8000; vec[1] = 16'h0000;
        run_query(N, 1, 0, 16'h8000, 1'b0, 0);

        // NaN seed is displaced by the first number.
        fill(16'hC400);
        vec[0] = 16'h7E00; vec[1] = 16'hC000;
        run_query(N, 1, 1, 16'hC000, 1'b0, 0);

        // Inf wins; a later NaN does not displace it.
        fill(16'h3C00);
        vec[7] = 16'h7C00; vec[8] = 16'h7E00;
        run_query(N, 1, 7, 16'h7C00, 1'b0, 0);

        // Short query flags error.
        fill(16'h0000);
        vec[0] = 16'h3800; vec[1] = 16'h4400; vec[2] = 16'h3C00; vec[3] = 16'h4000;
        run_query(4, 1, 1, 16'h4400, 1'b1, 0);

        // Next full query clean; negative ordering.
        fill(16'hC400);
        vec[0] = 16'hC400; vec[1] = 16'hC000; vec[2] = 16'hBC00; vec[3] = 16'hC200;
        run_query(N, 1, 2, 16'hBC00, 1'b0, 0);

        // Long query: ten scores without last, subnormal ordering.
        fill(16'h0000);
        vec[1] = 16'h0001; vec[2] = 16'h0400; vec[3] = 16'h03FF;
        run_query(N, 0, 2, 16'h0400, 1'b1, 0);

        // The overflow score starts a fresh query.
        fill(16'h0000);
        vec[0] = 16'h0001; vec[1] = 16'h0002; vec[3] = 16'h8001;
        run_query(N, 1, 1, 16'h0002, 1'b0, 0);

        // Result held for five cycles while a score is pending.
        rr_hold = 1'b1;
        fill(16'h3C00);
        vec[0] = 16'h4000; vec[1] = 16'h4200; vec[2] = 16'h4100;
        run_query(N, 1, 1, 16'h4200, 1'b0, 0);
        bus.score_valid = 1'b1;
        bus.score_data  = 16'h4000;
        bus.score_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.result_valid), 32'd1);
            check("hold_ready", 32'(bus.score_ready),  32'd0);
            check("hold_class", 32'(bus.result_class), 32'd1);
            check("hold_score", 32'(bus.result_score), 32'h4200);
        end
        rr_hold = 1'b0;
        fill(16'h3C00);
        vec[0] = 16'h4000; vec[9] = 16'h4000;
        run_query(N, 1, 0, 16'h4000, 1'b0, 0);

        // Random valid/ready gaps give identical results.
        rr_rand = 1'b1;
        fill(16'hC000);
        vec[0] = 16'h3C00; vec[1] = 16'h4000; vec[2] = 16'hBC00; vec[3] = 16'h3800;
        run_query(N, 1, 1, 16'h4000, 1'b0, 1);
        fill(16'hC400);
        vec[0] = 16'h7E00; vec[1] = 16'hC000;
        run_query(N, 1, 1, 16'hC000, 1'b0, 1);
        fill(16'h0000);
        vec[0] = 16'h3800; vec[1] = 16'h4400; vec[2] = 16'h3C00; vec[3] = 16'h4000;
        run_query(4, 1, 1, 16'h4400, 1'b1, 1);
        rr_rand = 1'b0;

        // Drain before the reset test.
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;

        // Reset at the sixth score drops the partial query.
        fill(16'h4000);
        for (int i = 0; i < 5; i++) drive_score(vec[i], 1'b0);
        bus.score_valid = 1'b1;
        bus.score_data  = 16'h7000;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midquery_reset");
        bus.score_valid = 1'b0;
        bus.score_data  = 16'hDEAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_midreset", 32'(bus.score_ready), 32'd1);
        @(posedge clk);
        #1;
        fill(16'h3C00);
        vec[4] = 16'h7BFE; vec[9] = 16'h7BFF;
        run_query(N, 1, 9, 16'h7BFF, 1'b0, 0);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
